// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - UART 8N1 receiver with FIFO behind a classic wishbone slave.
// Define WB_UART_RX_PARITY_EN to receive 8E1 frames with a sticky parity_err flag.
module wb_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    input  logic       i_wb_we,
    input  logic [1:0] i_wb_addr,
    input  logic [7:0] i_wb_data,
    output logic       o_wb_ack,
    output logic       o_wb_stall,
    output logic [7:0] o_wb_data,
    input  logic       i_uart_rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

`ifdef WB_UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic          rx_meta_q, rx_s_q, rx_s_d_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          push_q;
    logic          ferr_set_q;
    logic          frame_err_q;
    logic          overrun_q;
`ifdef WB_UART_RX_PARITY_EN
    logic          par_bad_q;
    logic          perr_set_q;
    logic          parity_err_q;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          ack_q;
    logic [7:0]    data_q;

    logic          accept, rd_req, wr_req, empty, full, pop, wr_en, ovr_set;
    logic [7:0]    clr, status, rd_val;
    logic          unused_wdata;

    assign o_wb_stall   = 1'b0;
    assign o_wb_ack     = ack_q;
    assign o_wb_data    = data_q;
    assign unused_wdata = ^{i_wb_data[7:3], i_wb_data[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_s_d_q  <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_s_d_q  <= rx_s_q;
        end
    end

    // Receive FSM; push_q/ferr_set_q are one-cycle pulses consumed by the FIFO/flag logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_set_q <= 1'b0;
`endif
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
            perr_set_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (rx_s_d_q && !rx_s_q) begin
                        cnt_q   <= CNT_HALF;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rx_s_q) begin
                        cnt_q   <= CNT_FULL;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q[idx_q] <= rx_s_q;
                        cnt_q          <= CNT_FULL;
                        if (idx_q == 3'd7) begin
`ifdef WB_UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef WB_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        par_bad_q  <= rx_s_q != ^shift_q;
                        perr_set_q <= rx_s_q != ^shift_q;
                        cnt_q      <= CNT_FULL;
                        state_q    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (rx_s_q) begin
`ifdef WB_UART_RX_PARITY_EN
                            push_q <= ~par_bad_q;
`else
                            push_q <= 1'b1;
`endif
                        end else begin
                            ferr_set_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign accept  = i_wb_cyc & i_wb_stb;
    assign rd_req  = accept & ~i_wb_we;
    assign wr_req  = accept & i_wb_we;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FIFO_FULL);
    assign pop     = rd_req && (i_wb_addr == 2'd0) && !empty;
    assign wr_en   = push_q && (!full || pop);
    assign ovr_set = push_q && full && !pop;
    assign clr     = (wr_req && i_wb_addr == 2'd1) ? i_wb_data : 8'h00;

`ifdef WB_UART_RX_PARITY_EN
    assign status = {4'b0, parity_err_q, frame_err_q, overrun_q, ~empty};
`else
    assign status = {5'b0, frame_err_q, overrun_q, ~empty};
`endif

    always_comb begin
        rd_val = 8'h00;
        case (i_wb_addr)
            2'd0:    rd_val = empty ? 8'h00 : mem_q[rd_ptr_q];
            2'd1:    rd_val = status;
            default: rd_val = 8'h00;
        endcase
    end

    // shift_q is stable in IDLE, so it still holds the finished byte when push_q fires.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q        <= 1'b0;
            data_q       <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            ack_q <= accept;
            if (rd_req) begin
                data_q <= rd_val;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overrun_q    <= ovr_set | (overrun_q & ~clr[1]);
            frame_err_q  <= ferr_set_q | (frame_err_q & ~clr[2]);
`ifdef WB_UART_RX_PARITY_EN
            parity_err_q <= perr_set_q | (parity_err_q & ~clr[3]);
`endif
        end
    end
endmodule

// File: tb/tb_wb_uart_rx.sv
// tb/tb_wb_uart_rx.sv - directed table-driven bench for wb_uart_rx (CLKS_PER_BIT=8, FIFO_DEPTH=4).
module tb_wb_uart_rx;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_wb_cyc, i_wb_stb, i_wb_we;
    logic [1:0] i_wb_addr;
    logic [7:0] i_wb_data;
    logic       o_wb_ack, o_wb_stall;
    logic [7:0] o_wb_data;
    logic       i_uart_rx;

    int checks = 0;
    int errors = 0;

    wb_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .i_uart_rx  (i_uart_rx)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_SEND, OP_READ, OP_WRITE} op_t;
    typedef struct {
        op_t        op;
        logic [1:0] addr;
        logic [7:0] data;
        logic       stop_ok;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        i_uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
        hold_bit(1'b1);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef WB_UART_RX_PARITY_EN
        hold_bit((^d) ^ par_flip);
`else
        if (par_flip) hold_bit(1'b1);
`endif
        hold_bit(stop_ok);
        if (stop_ok) i_uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
        @(posedge clk);
        #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        check({name, " ack"}, {7'b0, o_wb_ack}, 8'h01);
        check({name, " data"}, o_wb_data, exp);
        @(posedge clk);
        #1;
        check({name, " ack_drop"}, {7'b0, o_wb_ack}, 8'h00);
        check({name, " data_hold"}, o_wb_data, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input string name);
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
        @(posedge clk);
        #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        check({name, " wr_ack"}, {7'b0, o_wb_ack}, 8'h01);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{OP_SEND,  2'd0, 8'h55, 1'b1, 8'h00},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h01},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h55},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h00},
            '{OP_SEND,  2'd0, 8'h01, 1'b1, 8'h00},
            '{OP_SEND,  2'd0, 8'h02, 1'b1, 8'h00},
            '{OP_SEND,  2'd0, 8'h03, 1'b1, 8'h00},
            '{OP_SEND,  2'd0, 8'h04, 1'b1, 8'h00},
            '{OP_SEND,  2'd0, 8'h05, 1'b1, 8'h00},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h03},
            '{OP_WRITE, 2'd0, 8'hEE, 1'b1, 8'h00},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h01},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h02},
            '{OP_READ,  2'd2, 8'h00, 1'b1, 8'h00},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h03},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h04},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h00},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h02},
            '{OP_WRITE, 2'd1, 8'h02, 1'b1, 8'h00},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h00},
            '{OP_SEND,  2'd0, 8'hA3, 1'b0, 8'h00},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h04},
            '{OP_READ,  2'd0, 8'h00, 1'b1, 8'h00},
            '{OP_WRITE, 2'd1, 8'h04, 1'b1, 8'h00},
            '{OP_READ,  2'd1, 8'h00, 1'b1, 8'h00}
        };

        reset = 1'b0;
        i_uart_rx = 1'b1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = 2'd0; i_wb_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset ack", {7'b0, o_wb_ack}, 8'h00);
        check("reset data", o_wb_data, 8'h00);
        check("stall", {7'b0, o_wb_stall}, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(2'd1, 8'h00, "reset status");

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_SEND:  send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0);
                OP_READ:  bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
                OP_WRITE: bus_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
                default:  ;
            endcase
        end

        // Glitch: two low cycles must not start a frame.
        hold_bit(1'b1);
        i_uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        bus_read(2'd1, 8'h00, "glitch status");

        // Reset in the middle of a frame, then a clean 0x3C.
        hold_bit(1'b0);
        hold_bit(1'b1); hold_bit(1'b0); hold_bit(1'b1); hold_bit(1'b0);
        reset = 1'b0;
        i_uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        bus_read(2'd1, 8'h00, "post-reset status");
        send_frame(8'h3C, 1'b1, 1'b0);
        bus_read(2'd1, 8'h01, "3C status");
        bus_read(2'd0, 8'h3C, "3C data");
        bus_read(2'd1, 8'h00, "3C empty");

`ifdef WB_UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        bus_read(2'd1, 8'h01, "par ok status");
        bus_read(2'd0, 8'h07, "par ok data");
        send_frame(8'h07, 1'b1, 1'b1);
        bus_read(2'd1, 8'h08, "par bad status");
        bus_read(2'd0, 8'h00, "par bad data");
        bus_write(2'd1, 8'h08, "par clr");
        bus_read(2'd1, 8'h00, "par cleared");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
- UART 8N1 receiver peripheral and wishbone slave. It is the receive counterpart of wb_uart.
- Samples the serial input i_uart_rx and buffers received bytes in a small FIFO.
- The CPU reads the buffered bytes and status over the same classic-wishbone register interface that wb_uart uses.
- Mapped in the 0xc000xxxx IO window next to wb_uart; the SoC gates i_wb_cyc with its address decode.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit (50 MHz / 115200). Minimum 4.
- FIFO_DEPTH, 4: number of receive FIFO entries. Power of two, minimum 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- i_wb_cyc, input, 1: bus cycle; already qualified by the address decode.
- i_wb_stb, input, 1: strobe.
- i_wb_we, input, 1: write enable.
- i_wb_addr, input, 2: word register index.
- i_wb_data, input, 8: write data.
- o_wb_ack, output, 1: one-cycle acknowledge.
- o_wb_stall, output, 1: tied to 0.
- o_wb_data, output, 8: read data.
- i_uart_rx, input, 1: serial line; idles high; asynchronous to clk.

Behaviour:
- Reset (reset=0, asynchronous): o_wb_ack=0, o_wb_data=0x00, FSM=IDLE, FIFO emptied, overrun and frame_err cleared, synchroniser flops preset to 1.
- Input path: i_uart_rx passes through a 2-FF synchroniser to give rx_s. rx_s_d is the 1-cycle delayed copy, used for edge detection.
- Bus handshake:
  - A request is accepted on every cycle where i_wb_cyc & i_wb_stb; o_wb_stall is never asserted.
  - o_wb_ack pulses high the cycle after acceptance, for exactly one cycle per accepted request.
  - o_wb_data is registered in the same cycle as ack and holds its value until the next read.
- Register map:
  - addr 0, RX data (read): returns the FIFO head and pops it. If the FIFO is empty, returns 0x00 with no pop and no underflow. Writes are ignored.
  - addr 1, STATUS (read): {5'b0, frame_err, overrun, ~empty}.
  - addr 1, STATUS (write): write-1-to-clear; bit1 clears overrun, bit2 clears frame_err.
  - addr 2 and 3: read 0x00; writes are ignored. All accesses are still acked.
- Receive FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge (rx_s_d=1, rx_s=0), load the bit counter with CLKS_PER_BIT/2-1 and go to START.
  - START: at counter 0, sample rx_s. If 0, reload CLKS_PER_BIT-1, set bit index 0 and go to DATA. If 1, treat it as a glitch and return to IDLE with nothing recorded.
  - DATA: at each counter 0, shift rx_s into bit[index] (LSB first) and reload the counter. After bit 7, go to STOP.
  - STOP: at counter 0, sample rx_s.
    - If 1: push the byte.
    - If 0: set frame_err and drop the byte.
    - In both cases return to IDLE. A new frame needs a fresh falling edge, so a held-low break line produces only one frame_err.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
  - Push when full: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle: both happen and the count is unchanged. When full this is not an overrun.
  - Sticky flags: hardware set takes priority over a same-cycle W1C clear.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE.

Optional Feature:
- Macro: WB_UART_RX_PARITY_EN.
- Defined: the frame becomes 8E1. A PARITY state sits between DATA and STOP and samples one extra bit.
  - If that bit does not equal the XOR of the data bits, set sticky flag parity_err (STATUS bit3, W1C) and drop the byte. The byte is dropped even if the stop bit is good.
- Undefined: no PARITY state; STATUS bit3 reads 0 and writes to it are ignored.

Test Plan (all with CLKS_PER_BIT=8, FIFO_DEPTH=4):
- Send 0x55 8N1, then read STATUS -> 0x01. Read addr0 -> 0x55, ack exactly 1 cycle after stb. Read STATUS again -> 0x00.
- Drive i_uart_rx low for 2 cycles, then high -> no push; STATUS stays 0x00.
- Send 0x01..0x05 back-to-back -> STATUS=0x03. Reads return 0x01..0x04, then 0x00. Write 0x02 to addr1 -> STATUS=0x00.
- Send 0xA3 with the stop bit held low -> STATUS=0x04, FIFO empty. Write 0x04 to addr1 -> STATUS=0x00.
- Assert reset after 4 data bits, release it, then send 0x3C -> only 0x3C is received; no flags set.
- With WB_UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 (correct) -> 0x07 is received. Send 0x07 with parity bit 0 -> STATUS bit3 set, no push.
